// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding,
// capture-time WB bypass and load-use stall generation.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ID_Valid,
    input  logic [3:0]    ID_ALUControl,
    input  logic [DW-1:0] ID_ReadData1,
    input  logic [DW-1:0] ID_ReadData2,
    input  logic [DW-1:0] ID_Imm,
    input  logic          ID_ALUSrc,
    input  logic          ID_RegDst,
    input  logic [RW-1:0] ID_Rs,
    input  logic [RW-1:0] ID_Rt,
    input  logic [RW-1:0] ID_Rd,
    input  logic          ID_RegWrite,
    input  logic          ID_MemRead,
    input  logic          ID_MemWrite,
    input  logic          ID_MemToReg,
    input  logic          Flush,
    input  logic          MEM_RegWrite,
    input  logic [RW-1:0] MEM_WriteReg,
    input  logic [DW-1:0] MEM_ALUResult,
    input  logic          WB_RegWrite,
    input  logic [RW-1:0] WB_WriteReg,
    input  logic [DW-1:0] WB_WriteData,
    output logic          Stall,
    output logic          EX_Valid,
    output logic [3:0]    EX_ALUControl,
    output logic [DW-1:0] EX_A,
    output logic [DW-1:0] EX_B,
    output logic [DW-1:0] EX_StoreData,
    output logic [RW-1:0] EX_WriteReg,
    output logic          EX_RegWrite,
    output logic          EX_MemRead,
    output logic          EX_MemWrite,
    output logic          EX_MemToReg
);

    typedef struct packed {
        logic          valid;
        logic [3:0]    alu_ctl;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic          alu_src;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] write_reg;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } ex_t;

    ex_t q;
    ex_t cap;
    ex_t nxt;

    logic hazard;
    logic rs_use;
    logic rt_use;
    logic wb_byp_rs;
    logic wb_byp_rt;

    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // load-use: the loaded rt is needed by the instruction in ID
    always_comb begin
        rs_use = (q.rt == ID_Rs);
        rt_use = (q.rt == ID_Rt) && (!ID_ALUSrc || ID_MemWrite);
        hazard = q.valid && q.mem_read && (q.rt != '0)
                 && ID_Valid && (rs_use || rt_use);
        Stall  = hazard && !Flush;
    end

    // register file writes this cycle are not yet visible in ReadData
    always_comb begin
        wb_byp_rs = WB_RegWrite && (WB_WriteReg != '0)
                    && (WB_WriteReg == ID_Rs);
        wb_byp_rt = WB_RegWrite && (WB_WriteReg != '0)
                    && (WB_WriteReg == ID_Rt);
    end

    always_comb begin
        cap            = '0;
        cap.valid      = ID_Valid;
        cap.alu_ctl    = ID_ALUControl;
        cap.rd1        = wb_byp_rs ? WB_WriteData : ID_ReadData1;
        cap.rd2        = wb_byp_rt ? WB_WriteData : ID_ReadData2;
        cap.imm        = ID_Imm;
        cap.alu_src    = ID_ALUSrc;
        cap.rs         = ID_Rs;
        cap.rt         = ID_Rt;
        cap.write_reg  = ID_RegDst ? ID_Rd : ID_Rt;
        cap.reg_write  = ID_RegWrite;
        cap.mem_read   = ID_MemRead;
        cap.mem_write  = ID_MemWrite;
        cap.mem_to_reg = ID_MemToReg;
    end

    always_comb begin
        nxt = cap;
        if (Flush || Stall) begin
            nxt = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    always_comb begin
        mem_hit_a = MEM_RegWrite && (MEM_WriteReg != '0)
                    && (MEM_WriteReg == q.rs);
        mem_hit_b = MEM_RegWrite && (MEM_WriteReg != '0)
                    && (MEM_WriteReg == q.rt);
        wb_hit_a  = WB_RegWrite && (WB_WriteReg != '0)
                    && (WB_WriteReg == q.rs);
        wb_hit_b  = WB_RegWrite && (WB_WriteReg != '0)
                    && (WB_WriteReg == q.rt);
    end

    // MEM holds the younger result, so it outranks WB
    always_comb begin
        fwd_a = q.rd1;
        if (q.valid) begin
            case (1'b1)
                mem_hit_a: fwd_a = MEM_ALUResult;
                wb_hit_a:  fwd_a = WB_WriteData;
                default:   fwd_a = q.rd1;
            endcase
        end
    end

    always_comb begin
        fwd_b = q.rd2;
        if (q.valid) begin
            case (1'b1)
                mem_hit_b: fwd_b = MEM_ALUResult;
                wb_hit_b:  fwd_b = WB_WriteData;
                default:   fwd_b = q.rd2;
            endcase
        end
    end

    always_comb begin
        EX_Valid      = q.valid;
        EX_ALUControl = q.alu_ctl;
        EX_A          = fwd_a;
        EX_B          = q.alu_src ? q.imm : fwd_b;
        EX_StoreData  = fwd_b;
        EX_WriteReg   = q.write_reg;
        EX_RegWrite   = q.reg_write;
        EX_MemRead    = q.mem_read;
        EX_MemWrite   = q.mem_write;
        EX_MemToReg   = q.mem_to_reg;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard
// queue, plus sequences for reset, bypass and mid-stream reset.
module tb_id_ex_stage;

    logic        Clk;
    logic        Reset;
    logic        ID_Valid;
    logic [3:0]  ID_ALUControl;
    logic [31:0] ID_ReadData1;
    logic [31:0] ID_ReadData2;
    logic [31:0] ID_Imm;
    logic        ID_ALUSrc;
    logic        ID_RegDst;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic [4:0]  ID_Rd;
    logic        ID_RegWrite;
    logic        ID_MemRead;
    logic        ID_MemWrite;
    logic        ID_MemToReg;
    logic        Flush;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_WriteReg;
    logic [31:0] MEM_ALUResult;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_WriteData;
    logic        Stall;
    logic        EX_Valid;
    logic [3:0]  EX_ALUControl;
    logic [31:0] EX_A;
    logic [31:0] EX_B;
    logic [31:0] EX_StoreData;
    logic [4:0]  EX_WriteReg;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_MemToReg;

    id_ex_stage dut (
        .Clk(Clk),
        .Reset(Reset),
        .ID_Valid(ID_Valid),
        .ID_ALUControl(ID_ALUControl),
        .ID_ReadData1(ID_ReadData1),
        .ID_ReadData2(ID_ReadData2),
        .ID_Imm(ID_Imm),
        .ID_ALUSrc(ID_ALUSrc),
        .ID_RegDst(ID_RegDst),
        .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt),
        .ID_Rd(ID_Rd),
        .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg),
        .Flush(Flush),
        .MEM_RegWrite(MEM_RegWrite),
        .MEM_WriteReg(MEM_WriteReg),
        .MEM_ALUResult(MEM_ALUResult),
        .WB_RegWrite(WB_RegWrite),
        .WB_WriteReg(WB_WriteReg),
        .WB_WriteData(WB_WriteData),
        .Stall(Stall),
        .EX_Valid(EX_Valid),
        .EX_ALUControl(EX_ALUControl),
        .EX_A(EX_A),
        .EX_B(EX_B),
        .EX_StoreData(EX_StoreData),
        .EX_WriteReg(EX_WriteReg),
        .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ctl / e_ctl bit order: {RegWrite, MemRead, MemWrite, MemToReg}
    typedef struct {
        logic        v;
        logic [3:0]  alu;
        logic [31:0] rd1, rd2, imm;
        logic        src, dst;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  ctl;
        logic        fl;
        logic        mrw;
        logic [4:0]  mwr;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wwr;
        logic [31:0] wdat;
        logic        e_stall;
        logic        e_valid;
        logic [3:0]  e_alu;
        logic [31:0] e_a, e_b, e_sd;
        logic [4:0]  e_wr;
        logic [3:0]  e_ctl;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic v, input logic [3:0] alu,
        input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [31:0] imm, input logic src, input logic dst,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [3:0] ctl,
        input logic fl,
        input logic mrw, input logic [4:0] mwr,
        input logic [31:0] mres,
        input logic wrw, input logic [4:0] wwr,
        input logic [31:0] wdat,
        input logic es, input logic ev, input logic [3:0] ealu,
        input logic [31:0] ea, input logic [31:0] eb,
        input logic [31:0] esd, input logic [4:0] ewr,
        input logic [3:0] ectl);
        vec_t t;
        t.v = v; t.alu = alu; t.rd1 = rd1; t.rd2 = rd2;
        t.imm = imm; t.src = src; t.dst = dst;
        t.rs = rs; t.rt = rt; t.rd = rd; t.ctl = ctl; t.fl = fl;
        t.mrw = mrw; t.mwr = mwr; t.mres = mres;
        t.wrw = wrw; t.wwr = wwr; t.wdat = wdat;
        t.e_stall = es; t.e_valid = ev; t.e_alu = ealu;
        t.e_a = ea; t.e_b = eb; t.e_sd = esd;
        t.e_wr = ewr; t.e_ctl = ectl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        ID_Valid      = t.v;
        ID_ALUControl = t.alu;
        ID_ReadData1  = t.rd1;
        ID_ReadData2  = t.rd2;
        ID_Imm        = t.imm;
        ID_ALUSrc     = t.src;
        ID_RegDst     = t.dst;
        ID_Rs         = t.rs;
        ID_Rt         = t.rt;
        ID_Rd         = t.rd;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg} = t.ctl;
        Flush         = t.fl;
        MEM_RegWrite  = t.mrw;
        MEM_WriteReg  = t.mwr;
        MEM_ALUResult = t.mres;
        WB_RegWrite   = t.wrw;
        WB_WriteReg   = t.wwr;
        WB_WriteData  = t.wdat;
    endtask

    function automatic logic [3:0] ex_ctl();
        return {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg};
    endfunction

    task automatic clear_in();
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
    endtask

    task automatic rand_in();
        ID_Valid      = 1'($urandom);
        ID_ALUControl = 4'($urandom);
        ID_ReadData1  = $urandom;
        ID_ReadData2  = $urandom;
        ID_Imm        = $urandom;
        ID_ALUSrc     = 1'($urandom);
        ID_RegDst     = 1'($urandom);
        ID_Rs         = 5'($urandom);
        ID_Rt         = 5'($urandom);
        ID_Rd         = 5'($urandom);
        ID_RegWrite   = 1'($urandom);
        ID_MemRead    = 1'($urandom);
        ID_MemWrite   = 1'($urandom);
        ID_MemToReg   = 1'($urandom);
        Flush         = 1'($urandom);
        MEM_RegWrite  = 1'($urandom);
        MEM_WriteReg  = 5'($urandom);
        MEM_ALUResult = $urandom;
        WB_RegWrite   = 1'($urandom);
        WB_WriteReg   = 5'($urandom);
        WB_WriteData  = $urandom;
    endtask

    task automatic fill_table();
        // add r3,r1,r2
        tbl.push_back(mk(1, 4'b0010, 5, 7, 0, 0, 1, 1, 2, 3, 4'b1000, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 5, 7, 7, 3, 4'b1000));
        // sub, RegDst=0 selects rt
        tbl.push_back(mk(1, 4'b0110, 'h100, 'h20, 0, 0, 0, 6, 7, 9,
            4'b1000, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0110, 'h100, 'h20, 'h20, 7, 4'b1000));
        // MEM and WB both write r4: MEM wins
        tbl.push_back(mk(1, 4'b0000, 'h44, 'h55, 0, 0, 1, 4, 5, 6,
            4'b1000, 0,
            1, 4, 'hAAAA0000, 1, 4, 'h11,
            0, 1, 4'b0000, 'hAAAA0000, 'h55, 'h55, 6, 4'b1000));
        tbl.push_back(mk(1, 4'b0000, 'h44, 'h55, 0, 0, 1, 4, 5, 6,
            4'b1000, 0,
            0, 4, 'hAAAA0000, 1, 4, 'h11,
            0, 1, 4'b0000, 'h11, 'h55, 'h55, 6, 4'b1000));
        // r0 is never forwarded
        tbl.push_back(mk(1, 4'b0001, 'h77, 'h55, 0, 0, 1, 0, 5, 6,
            4'b1000, 0,
            1, 0, 'hAAAA0000, 1, 0, 'h11,
            0, 1, 4'b0001, 'h77, 'h55, 'h55, 6, 4'b1000));
        // sw with immediate, store data forwarded from MEM
        tbl.push_back(mk(1, 4'b0010, 'h1000, 'h99, 'hFFFFFFFC, 1, 0,
            1, 9, 0, 4'b0010, 0,
            1, 9, 'h55, 0, 0, 0,
            0, 1, 4'b0010, 'h1000, 'hFFFFFFFC, 'h55, 9, 4'b0010));
        // lw r2 then add r5,r2,r1: stall, bubble, reissue
        tbl.push_back(mk(1, 4'b0010, 'h2000, 'h22, 4, 1, 0, 1, 2, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h2000, 4, 'h22, 2, 4'b1101));
        tbl.push_back(mk(1, 4'b0010, 'hBAD, 3, 0, 0, 1, 2, 1, 5,
            4'b1000, 0,
            0, 0, 0, 0, 0, 0,
            1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 'hBAD, 3, 0, 0, 1, 2, 1, 5,
            4'b1000, 0,
            0, 0, 0, 1, 2, 'h1234,
            0, 1, 4'b0010, 'h1234, 3, 3, 5, 4'b1000));
        // same hazard with Flush: no stall, bubble
        tbl.push_back(mk(1, 4'b0010, 'h2000, 'h22, 4, 1, 0, 1, 2, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h2000, 4, 'h22, 2, 4'b1101));
        tbl.push_back(mk(1, 4'b0010, 'hBAD, 3, 0, 0, 1, 2, 1, 5,
            4'b1000, 1,
            0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0));
        // back-to-back dependent loads
        tbl.push_back(mk(1, 4'b0010, 'h3000, 'h33, 8, 1, 0, 1, 3, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h3000, 8, 'h33, 3, 4'b1101));
        tbl.push_back(mk(1, 4'b0010, 3, 'h44, 0, 1, 0, 3, 4, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 3, 'h44, 0, 1, 0, 3, 4, 0,
            4'b1101, 0,
            0, 0, 0, 1, 3, 'h40,
            0, 1, 4'b0010, 'h40, 0, 'h44, 4, 4'b1101));
        // sw of the just-loaded rt stalls even with ALUSrc=1
        tbl.push_back(mk(1, 4'b0010, 1, 4, 0, 1, 0, 1, 4, 0,
            4'b0010, 0,
            0, 0, 0, 0, 0, 0,
            1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 4, 0, 1, 0, 1, 4, 0,
            4'b0010, 0,
            0, 0, 0, 1, 4, 'h4444,
            0, 1, 4'b0010, 1, 0, 'h4444, 4, 4'b0010));
        // addi whose rt matches the load: no stall
        tbl.push_back(mk(1, 4'b0010, 'h10, 0, 0, 1, 0, 1, 7, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h10, 0, 0, 7, 4'b1101));
        tbl.push_back(mk(1, 4'b0010, 'h20, 'h70, 5, 1, 0, 1, 7, 0,
            4'b1000, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h20, 5, 'h70, 7, 4'b1000));
        // invalid ID slot behind a load: no stall
        tbl.push_back(mk(1, 4'b0010, 'h10, 0, 0, 1, 0, 1, 7, 0,
            4'b1101, 0,
            0, 0, 0, 0, 0, 0,
            0, 1, 4'b0010, 'h10, 0, 0, 7, 4'b1101));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0,
            0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t e;
        Reset = 1'b0;
        rand_in();
        fill_table();

        // reset with random ID traffic
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            rand_in();
            @(posedge Clk);
            #1;
            chk("rst_valid", 32'(EX_Valid), 0);
            chk("rst_ctl", 32'(ex_ctl()), 0);
            chk("rst_alu", 32'(EX_ALUControl), 0);
            chk("rst_a", EX_A, 0);
            chk("rst_b", EX_B, 0);
            chk("rst_stall", 32'(Stall), 0);
        end

        @(negedge Clk);
        Reset = 1'b1;
        foreach (tbl[i]) begin
            if (i != 0) @(negedge Clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(Stall),
                32'(tbl[i].e_stall));
            @(posedge Clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), 32'(EX_Valid),
                32'(e.e_valid));
            chk($sformatf("v%0d_alu", i), 32'(EX_ALUControl),
                32'(e.e_alu));
            chk($sformatf("v%0d_a", i), EX_A, e.e_a);
            chk($sformatf("v%0d_b", i), EX_B, e.e_b);
            chk($sformatf("v%0d_sd", i), EX_StoreData, e.e_sd);
            chk($sformatf("v%0d_wr", i), 32'(EX_WriteReg),
                32'(e.e_wr));
            chk($sformatf("v%0d_ctl", i), 32'(ex_ctl()),
                32'(e.e_ctl));
        end

        // capture-time bypass, then live WB and MEM forwarding
        @(negedge Clk);
        clear_in();
        ID_Valid = 1; ID_ALUControl = 4'b0001;
        ID_Rs = 8; ID_Rt = 9; ID_Rd = 10; ID_RegDst = 1;
        ID_ReadData1 = 'hDEAD; ID_ReadData2 = 'h9;
        ID_RegWrite = 1;
        WB_RegWrite = 1; WB_WriteReg = 8; WB_WriteData = 'hBEEF;
        @(posedge Clk);
        #1;
        WB_RegWrite = 0;
        #1;
        chk("byp_a", EX_A, 'hBEEF);
        chk("byp_b", EX_B, 'h9);
        WB_RegWrite = 1; WB_WriteData = 'h5;
        #1;
        chk("wbf_a", EX_A, 'h5);
        MEM_RegWrite = 1; MEM_WriteReg = 8; MEM_ALUResult = 'h6;
        #1;
        chk("memf_a", EX_A, 'h6);
        MEM_WriteReg = 9;
        #1;
        chk("memf_a2", EX_A, 'h5);
        chk("memf_b", EX_B, 'h6);
        chk("memf_sd", EX_StoreData, 'h6);

        // reset while a stall is pending
        @(negedge Clk);
        clear_in();
        ID_Valid = 1; ID_ALUControl = 4'b0010;
        ID_Rs = 1; ID_Rt = 2; ID_ALUSrc = 1; ID_Imm = 4;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg} = 4'b1101;
        @(negedge Clk);
        clear_in();
        ID_Valid = 1; ID_ALUControl = 4'b0010;
        ID_Rs = 2; ID_Rt = 1; ID_Rd = 5; ID_RegDst = 1;
        ID_RegWrite = 1;
        #1;
        chk("mr_stall_pre", 32'(Stall), 1);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("mr_stall_post", 32'(Stall), 0);
        chk("mr_valid", 32'(EX_Valid), 0);
        chk("mr_ctl", 32'(ex_ctl()), 0);
        @(negedge Clk);
        Reset = 1'b1;
        ID_Valid = 0;
        @(posedge Clk);
        #1;
        chk("mr_idle", 32'(EX_Valid), 0);
        @(negedge Clk);
        ID_Valid = 1;
        @(posedge Clk);
        #1;
        chk("mr_resume", 32'(EX_Valid), 1);
        chk("mr_wr", 32'(EX_WriteReg), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
